// File: rtl/week6_xor_parity_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared serial
// parity engine.
interface week6_xor_parity_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic             parity;
   logic             owner;

   modport master (
      output req0,
      output data0,
      output req1,
      output data1,
      input  gnt0,
      input  gnt1,
      input  busy,
      input  done,
      input  parity,
      input  owner
   );

   modport slave (
      input  req0,
      input  data0,
      input  req1,
      input  data1,
      output gnt0,
      output gnt1,
      output busy,
      output done,
      output parity,
      output owner
   );
endinterface

// File: rtl/week6_xor_parity_arbiter.sv
// Round-robin arbiter sharing one bit-serial XOR accumulator between two
// requesters; reports the even-parity bit of the granted word with a done pulse.
module week6_xor_parity_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   week6_xor_parity_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state,  state_n;
   logic [WIDTH-1:0] sh,     sh_n;
   logic             acc,    acc_n;
   logic [CNT_W-1:0] cnt,    cnt_n;
   logic             last,   last_n;
   logic             gnt0,   gnt0_n;
   logic             gnt1,   gnt1_n;
   logic             busy,   busy_n;
   logic             done,   done_n;
   logic             parity, parity_n;
   logic             owner,  owner_n;
   logic             win;
   logic             any_req;

   // Winner selection: a lone request wins outright, a tie goes to the
   // requester that did not own the previous job.
   always_comb begin
      any_req = bus.req0 | bus.req1;
      win     = 1'b0;
      if (bus.req0 && bus.req1) begin
         win = ~last;
      end else begin
         win = bus.req1;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state;
      sh_n     = sh;
      acc_n    = acc;
      cnt_n    = cnt;
      last_n   = last;
      owner_n  = owner;
      parity_n = parity;
      gnt0_n   = 1'b0;
      gnt1_n   = 1'b0;
      done_n   = 1'b0;

      case (state)
         IDLE: begin
            if (any_req) begin
               sh_n    = win ? bus.data1 : bus.data0;
               acc_n   = 1'b0;
               cnt_n   = '0;
               owner_n = win;
               last_n  = win;
               gnt0_n  = ~win;
               gnt1_n  = win;
               state_n = SHIFT;
            end
         end

         SHIFT: begin
            acc_n = acc ^ sh[0];
            sh_n  = sh >> 1;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               parity_n = acc ^ sh[0];
               done_n   = 1'b1;
               state_n  = DONE;
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sh     <= '0;
         acc    <= 1'b0;
         cnt    <= '0;
         last   <= 1'b1;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         parity <= 1'b0;
         owner  <= 1'b0;
      end else begin
         state  <= state_n;
         sh     <= sh_n;
         acc    <= acc_n;
         cnt    <= cnt_n;
         last   <= last_n;
         gnt0   <= gnt0_n;
         gnt1   <= gnt1_n;
         busy   <= busy_n;
         done   <= done_n;
         parity <= parity_n;
         owner  <= owner_n;
      end
   end

   assign bus.gnt0   = gnt0;
   assign bus.gnt1   = gnt1;
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.parity = parity;
   assign bus.owner  = owner;
endmodule

// File: tb/tb_week6_xor_parity_arbiter.sv
// Directed and randomized check of the shared-parity arbiter against a
// job-level reference model.
module tb_week6_xor_parity_arbiter;
   localparam int unsigned WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   week6_xor_parity_arbiter_if #(.WIDTH(WIDTH)) bus ();

   week6_xor_parity_arbiter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int prev_gnt_cyc = 0;

   // Reference model state: who owned the last job and the visible results.
   logic m_last   = 1'b1;
   logic m_parity = 1'b0;
   logic m_owner  = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic g0, input logic g1,
                          input logic b, input logic d, input logic p, input logic o);
      chk({tag, ".gnt0"},   bus.gnt0,   g0);
      chk({tag, ".gnt1"},   bus.gnt1,   g1);
      chk({tag, ".busy"},   bus.busy,   b);
      chk({tag, ".done"},   bus.done,   d);
      chk({tag, ".parity"}, bus.parity, p);
      chk({tag, ".owner"},  bus.owner,  o);
   endtask

   function automatic logic ref_parity(input logic [WIDTH-1:0] d);
      return (($countones(d) % 2) == 1);
   endfunction

   // One complete job from the grant edge to the following IDLE cycle.
   task automatic do_job(input string tag, input logic r0, input logic r1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input bit hold, input bit perturb, input bit spaced);
      logic win;
      logic exp_p;
      chk({tag, ".pre_idle"}, bus.busy, 1'b0);
      bus.req0  = r0;
      bus.req1  = r1;
      bus.data0 = d0;
      bus.data1 = d1;
      win   = (r0 && r1) ? !m_last : r1;
      exp_p = ref_parity(win ? d1 : d0);
      tick();
      if (spaced) chk_int({tag, ".spacing"}, cyc - prev_gnt_cyc, WIDTH + 2);
      prev_gnt_cyc = cyc;
      m_last  = win;
      m_owner = win;
      chk_out({tag, ".grant"}, !win, win, 1'b1, 1'b0, m_parity, m_owner);
      if (!hold) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
      end
      for (int c = 2; c <= int'(WIDTH); c++) begin
         if (perturb && c == 3) begin
            bus.data0 = WIDTH'(1);
            bus.data1 = WIDTH'($urandom);
            bus.req1  = 1'b1;
         end
         tick();
         chk_out($sformatf("%s.shift%0d", tag, c), 1'b0, 1'b0, 1'b1, 1'b0, m_parity, m_owner);
      end
      tick();
      m_parity = exp_p;
      chk_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1, m_parity, m_owner);
      tick();
      chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, m_parity, m_owner);
   endtask

   initial begin
      logic r0;
      logic r1;
      rst_n     = 1'b0;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.data0 = 8'hFF;
      bus.data1 = 8'h01;

      // Reset holds everything low even with both requests pending.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst_n = 1'b1;

      // Round-robin with both requests held: order 0,1,0,1, spacing WIDTH+2.
      do_job("rr0", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      do_job("rr1", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
      do_job("rr2", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
      do_job("rr3", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);

      tick();
      chk_out("gap", 1'b0, 1'b0, 1'b0, 1'b0, m_parity, m_owner);

      do_job("a5", 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
      do_job("80", 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
      do_job("r1_07", 1'b0, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0);

      // Data/request changes during SHIFT must not disturb the running job.
      do_job("iso", 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
      do_job("iso_next", 1'b0, 1'b1, 8'h01, 8'h07, 1'b0, 1'b0, 1'b0);

      // Reset in the 4th SHIFT cycle discards the job.
      bus.req0  = 1'b1;
      bus.data0 = 8'h01;
      tick();
      m_owner = 1'b0;
      chk_out("mid.grant", 1'b1, 1'b0, 1'b1, 1'b0, m_parity, m_owner);
      bus.req0 = 1'b0;
      for (int c = 2; c <= 4; c++) tick();
      chk("mid.busy4", bus.busy, 1'b1);
      rst_n = 1'b0;
      tick();
      chk_out("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mid.rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n    = 1'b1;
      m_last   = 1'b1;
      m_parity = 1'b0;
      m_owner  = 1'b0;
      tick();
      chk_out("mid.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Tie right after reset must go to requester 0 again.
      do_job("post", 1'b1, 1'b1, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0);

      for (int j = 0; j < 20; j++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         do_job($sformatf("rnd%0d", j), r0, r1, WIDTH'($urandom), WIDTH'($urandom),
                1'b0, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/week6_xor_parity_arbiter.md
Name: week6_xor_parity_arbiter

Overview:
- Shares one serial XOR accumulator between two requesters. The accumulator computes the even-parity bit of a WIDTH-bit word, one bit per cycle.
- Round-robin arbitration selects the requester. The block captures that requester's word and sequences it through the XOR datapath. It then reports the result with a done pulse.
- It is the sequencing/arbitration layer above the two-input XOR gate exercises. It is the first clocked block in that series.

Parameters:
WIDTH, 8, word length in bits processed per job; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
req0  input  1  level request from requester 0.
data0  input  WIDTH  word from requester 0; sampled only on the grant edge.
req1  input  1  level request from requester 1.
data1  input  WIDTH  word from requester 1; sampled only on the grant edge.
gnt0  output  1  one-cycle grant pulse to requester 0.
gnt1  output  1  one-cycle grant pulse to requester 1.
busy  output  1  high while a job is in progress (state != IDLE).
done  output  1  one-cycle pulse; parity is valid for the current job.
parity  output  1  XOR of all WIDTH bits of the granted word; held until the next grant.
owner  output  1  index of the requester owning the current or last job; held until the next grant.

Behaviour:
- Interface: single clock domain clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk. All outputs are registered.
- Reset values:
  - gnt0 = gnt1 = busy = done = parity = owner = 0.
  - state = IDLE.
  - The round-robin pointer last = 1, so req0 wins the first tie.
  - The shift register, accumulator and counter are all 0.
- FSM states are IDLE, SHIFT, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last.
  - On the grant edge:
    - latch the winner's data into the shift register;
    - acc <= 0, cnt <= 0;
    - owner <= winner, last <= winner;
    - gnt<winner> <= 1 for one cycle;
    - go to SHIFT.
- SHIFT, on each edge:
  - acc <= acc ^ sh[0];
  - sh <= sh >> 1;
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: parity <= acc ^ sh[0], done <= 1, go to DONE.
  - SHIFT therefore lasts exactly WIDTH cycles.
- DONE: lasts one cycle (done=1, busy=1), then IDLE with done <= 0.
- Latency: with the grant edge as E0:
  - gnt is high in cycle 1;
  - SHIFT occupies cycles 1..WIDTH;
  - done is high in cycle WIDTH+1;
  - the earliest next grant edge is the end of cycle WIDTH+2.
  - Back-to-back job spacing is WIDTH+2 cycles.
- Requests are level-sensitive and evaluated only in IDLE. req/data changes during SHIFT or DONE are ignored.
- A requester that keeps req high after done is re-arbitrated against the other. Round-robin guarantees alternation when both are held high.
- gnt0 and gnt1 are never high together. done and gnt are never high together.
- parity and owner change only on a grant edge (owner) or the final SHIFT edge (parity). They are stable at all other times.
- The counter is $clog2(WIDTH)+1 bits. There is no wrap-around in normal use. cnt is cleared on every grant.
- Reset mid-operation (any state): the next edge forces all reset values, including parity=0, owner=0 and last=1. Any in-flight job is discarded with no done pulse.

Test Plan:
1. Reset values: hold rst_n=0 for 3 cycles with req0=req1=1 -> gnt0=gnt1=busy=done=parity=owner=0 throughout. On release, the first grant goes to req0.
2. Single job: WIDTH=8, req0=1, data0=8'hA5 for one cycle in IDLE -> gnt0 pulse in cycle 1, busy for cycles 1..9, done in cycle 9, parity=0, owner=0. Also check data0=8'h80 -> parity=1.
3. Requester 1: req1=1, data1=8'h07 -> gnt1 pulse, done 9 cycles after the grant edge, parity=1, owner=1; gnt0 stays 0.
4. Round-robin: hold req0=req1=1 from reset with data0=8'hFF, data1=8'h01 -> grant order 0,1,0,1. Parity results alternate 0,1,0,1. Successive grants are spaced 10 cycles apart.
5. Data isolation: after gnt0 for data0=8'h0F, change data0 to 8'h01 and pulse req1 during SHIFT -> parity=0, no gnt1 before done, gnt1 in the next IDLE.
6. Reset mid-job: assert rst_n=0 in the 4th SHIFT cycle of a job on 8'h01 -> no done pulse, parity=0, busy=0 the next cycle. After release, a new req0 job on 8'h01 completes with parity=1.
